// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle 32-bit restoring divider for DIV/DIVU
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] work, work_n;
  logic [31:0] divisor, divisor_n;
  logic        sign_a, sign_a_n;
  logic        sign_b, sign_b_n;
  logic        is_signed, is_signed_n;
  logic [63:0] result_n;
  logic        ready_n;

  // Combinational helpers: operand magnitudes, trial subtraction, sign fix-up.
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] trial;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand conditioning and final sign correction; abs(0x80000000) stays 2^31.
  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    trial        = {1'b0, work[63:32]} - {1'b0, divisor};
    quot_raw     = work[31:0];
    rem_raw      = work[64:33];
    quot_fix     = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - quot_raw) : quot_raw;
    rem_fix      = (is_signed && sign_a) ? (32'd0 - rem_raw) : rem_raw;
  end

  // Next-state and next-output logic for the division sequencer.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    work_n      = work;
    divisor_n   = divisor;
    sign_a_n    = sign_a;
    sign_b_n    = sign_b;
    is_signed_n = is_signed;
    result_n    = result_o;
    ready_n     = ready_o;
    case (state)
      FREE: begin
        ready_n  = 1'b0;
        result_n = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_n = BYZERO;
          end else begin
            state_n     = ON;
            cnt_n       = 6'd0;
            work_n      = {32'd0, dividend_abs, 1'b0};
            divisor_n   = divisor_abs;
            sign_a_n    = opdata1_i[31];
            sign_b_n    = opdata2_i[31];
            is_signed_n = signed_div_i;
          end
        end
      end
      BYZERO: begin
        state_n  = END;
        result_n = 64'd0;
        ready_n  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = 64'd0;
        end else if (cnt != 6'd32) begin
          if (trial[32]) begin
            work_n = {work[63:0], 1'b0};
          end else begin
            work_n = {trial[31:0], work[31:0], 1'b1};
          end
          cnt_n = cnt + 6'd1;
        end else begin
          state_n  = END;
          result_n = {rem_fix, quot_fix};
          ready_n  = 1'b1;
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = 64'd0;
        end
      end
      default: begin
        state_n  = FREE;
        ready_n  = 1'b0;
        result_n = 64'd0;
      end
    endcase
  end

  // State, datapath and registered outputs; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FREE;
      cnt       <= 6'd0;
      work      <= 65'd0;
      divisor   <= 32'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      result_o  <= 64'd0;
      ready_o   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      work      <= work_n;
      divisor   <= divisor_n;
      sign_a    <= sign_a_n;
      sign_b    <= sign_b_n;
      is_signed <= is_signed_n;
      result_o  <= result_n;
      ready_o   <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests_run = 0;
  int tests_failed = 0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Start a division, scramble operands after the sample edge, then check
  // latency, result, hold while start stays high, and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int n;
    @(negedge clk);
    annul_i      = 1'b0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    signed_div_i = ~sgn;
    opdata1_i    = 32'h1234_5678;
    opdata2_i    = 32'h0000_0005;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    @(posedge clk);
    #1;
    check({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u 100/7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    run_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, 33, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s 7/-2", 1'b1, 32'h7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    run_div("s -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 64'hFFFFFFFE_0000000E);
    run_div("u FFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'h2, 33, 64'h00000001_7FFFFFFC);
    run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    run_div("u FFFFFFFF/1", 1'b0, 32'hFFFFFFFF, 32'h1, 33, 64'h00000000_FFFFFFFF);
    run_div("u x/0", 1'b0, 32'd55, 32'd0, 1, 64'd0);
    run_div("s x/0", 1'b1, 32'hFFFFFF00, 32'd0, 1, 64'd0);

    // Annul at iteration 10, then a new 9/3 accepted on the very next edge.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    if (ready_o) seen = 1;
    check("annul ready never", 64'(seen), 64'd0);
    check("annul result", result_o, 64'd0);
    run_div("u 9/3 after annul", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

    // Async reset in END clears held outputs without a clock edge.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd4;
    start_i      = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("pre-rst result", result_o, 64'h00000002_0000000C);
    #2;
    rst = 1'b1;
    #1;
    check("async rst ready end", 64'(ready_o), 64'd0);
    check("async rst result end", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;

    // Async reset mid-iteration returns to FREE; next division has full latency.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst ready on", 64'(ready_o), 64'd0);
    check("async rst result on", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    run_div("u 20/6 after rst", 1'b0, 32'd20, 32'd6, 33, 64'h00000002_00000003);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
